surf4_hk_sequencer: RTL and testbench
=====================================

// Module: surf4_hk_sequencer
// PURPOSE
// - PPS-triggered housekeeping scanner, directly upstream of the housekeeping buffer.
// - Each PPS: reads a fixed list of XADC status registers over a WISHBONE master port
//   (XADC window 0x0200-0x03FC), then writes one tagged record into the buffer write port.
// - Record is later DMA'd to TURF/PCI.
// PARAMETERS
// - NUM_CH      6      channels scanned; max 8. Table idx0..7 = XADC reg 0x00,0x01,0x02,0x03,0x06,0x1A,0x04,0x05.
// - TIMEOUT     255    cycles to wait for ack_i before abandoning an access.
// - BUF_AW      5      buffer word-address width; record base = 0, wraps mod 2^BUF_AW.
// PORTS
// - clk_i         in   1   system clock
// - rst_i         in   1   asynchronous active-high reset
// - pps_i         in   1   PPS, asynchronous; double-synchronised internally
// - wbm_cyc_o     out  1   WB cycle
// - wbm_stb_o     out  1   WB strobe
// - wbm_we_o      out  1   WB write enable, always 0
// - wbm_adr_o     out  16  WB byte address = 0x0200 + (xadc_reg<<2)
// - wbm_dat_o     out  32  always 0
// - wbm_sel_o     out  4   always 4'hF
// - wbm_dat_i     in   32  read data; [15:0] used
// - wbm_ack_i     in   1   WB acknowledge
// - buf_we_o      out  1   buffer write strobe, one cycle per word
// - buf_adr_o     out  BUF_AW  buffer word address
// - buf_dat_o     out  32  buffer write data
// - busy_o        out  1   high from PPS accept until DONE
// - done_o        out  1   one-cycle pulse at record completion
// - missed_o      out  1   sticky: PPS arrived while busy; cleared by reset only
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, seq counter 0, sync FFs 0.
// - PPS edge = sync[1] & ~sync[2]. Latency from pps_i rising to wbm_cyc_o is 3 clk.
// - FSM states and transitions:
//   - IDLE -> REQ on edge; ch=0.
//   - REQ: cyc=stb=1, adr from table[ch]; timer=0.
//   - REQ -> STORE on ack_i: latch dat_i[15:0], flag=0; cyc/stb drop the same edge.
//   - REQ -> STORE on timer==TIMEOUT: data=16'hDEAD, flag=1; cyc/stb drop.
//   - STORE: buf_we=1, adr=1+ch, dat={flag,7'b0,5'b0,ch[2:0],data16}.
//   - STORE -> REQ if ch<NUM_CH-1 (ch++), else HDR.
//   - HDR: buf_we=1, adr=0, dat={seq[15:0],8'h0,NUM_CH[7:0]}; seq++ (16-bit wrap).
//   - HDR -> DONE; DONE: done_o=1 -> IDLE.
// - Header is written last so consumers see a new seq only when all data words are valid.
// - Record is NUM_CH+1 words. With HK_SEQ_TIMESTAMP_EN: NUM_CH+2 words.
// - Buffer addresses wrap mod 2^BUF_AW. A record exceeding 2^BUF_AW overwrites its
//   lowest words; documented misuse, not guarded.
// - PPS edge while busy: ignored, missed_o set. The edge in the same cycle as DONE is
//   also ignored.
// - ack_i outside REQ is ignored. ack_i on the same cycle the timer hits TIMEOUT:
//   ack wins, flag=0.
// - Reset mid-scan: immediate abort, cyc/stb low asynchronously, no partial header.
// CONFIGURATION
// - HK_SEQ_TIMESTAMP_EN defined:
//   - 32-bit free-running seconds counter, incremented on every PPS edge including missed.
//   - Written at adr NUM_CH+1 in a TSTAMP state between the last STORE and HDR.
// - Undefined: no counter, no TSTAMP state, record NUM_CH+1 words.
// TESTING
// - 1. Single PPS, slave acks 2 clk after stb, dat_i=0x0000_9A50 on reg 0x00
//   -> buf word1=0x0000_9A50; header 0x0000_0006 written last; done_o pulses once.
// - 2. Two scans -> second header=0x0001_0006; addresses 1..6 then 0, identical both scans.
// - 3. Slave never acks reg 0x02 (ch2) -> after 255 clk cyc drops;
//   word3=0x8002_DEAD; remaining channels read normally.
// - 4. Second PPS 10 clk into scan -> missed_o=1, exactly one record, seq +1 only.
// - 5. Assert rst_i while in REQ for ch3 -> cyc_o=0 same cycle; no buf_we after;
//   next PPS header seq=0.
// - 6. HK_SEQ_TIMESTAMP_EN, 3 PPS -> word7=1,2,3 per record; header still 0x000N_0006.

Source files
------------

// File: rtl/surf4_hk_sequencer.sv
// surf4_hk_sequencer: once per PPS, reads NUM_CH XADC status registers over a WISHBONE
// master port and writes one tagged record (data words, then header last) into the
// housekeeping buffer write port.
// Ports: clk_i/rst_i (async active-high), pps_i (async), wbm_* WISHBONE read master,
//        buf_we_o/buf_adr_o/buf_dat_o buffer write port, busy_o, done_o, missed_o (sticky).
// Optional: define HK_SEQ_TIMESTAMP_EN to add a PPS seconds counter word at NUM_CH+1.
module surf4_hk_sequencer #(
    parameter int NUM_CH  = 6,
    parameter int TIMEOUT = 255,
    parameter int BUF_AW  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pps_i,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [15:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    output logic [3:0]        wbm_sel_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    output logic              buf_we_o,
    output logic [BUF_AW-1:0] buf_adr_o,
    output logic [31:0]       buf_dat_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              missed_o
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_STORE  = 3'd2,
        S_HDR    = 3'd3,
        S_DONE   = 3'd4
`ifdef HK_SEQ_TIMESTAMP_EN
        , S_TSTAMP = 3'd5
`endif
    } state_t;

    state_t        r_state, w_next;
    logic [2:0]    r_pps_sync;
    logic [2:0]    r_ch;
    logic [TW-1:0] r_timer;
    logic [15:0]   r_data;
    logic          r_flag;
    logic [15:0]   r_seq;
    logic          r_missed;
    logic          w_pps_edge;
    logic          w_timeout;
    logic          w_last_ch;
    logic [31:0]   w_adr_full;
    logic          w_unused_dat_hi;
`ifdef HK_SEQ_TIMESTAMP_EN
    logic [31:0]   r_ts;
`endif

    // Only the low half of the XADC read data carries status.
    assign w_unused_dat_hi = &wbm_dat_i[31:16];

    // XADC register map order for channel index 0..7.
    function automatic logic [7:0] xadc_reg(input logic [2:0] idx);
        case (idx)
            3'd0:    xadc_reg = 8'h00;
            3'd1:    xadc_reg = 8'h01;
            3'd2:    xadc_reg = 8'h02;
            3'd3:    xadc_reg = 8'h03;
            3'd4:    xadc_reg = 8'h06;
            3'd5:    xadc_reg = 8'h1A;
            3'd6:    xadc_reg = 8'h04;
            default: xadc_reg = 8'h05;
        endcase
    endfunction

    assign w_pps_edge = r_pps_sync[1] & ~r_pps_sync[2];
    assign w_timeout  = (r_timer == TW'(TIMEOUT));
    assign w_last_ch  = ({29'b0, r_ch} >= 32'(NUM_CH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_pps_sync <= 3'b0;
            r_ch       <= 3'b0;
            r_timer    <= '0;
            r_data     <= 16'h0;
            r_flag     <= 1'b0;
            r_seq      <= 16'h0;
            r_missed   <= 1'b0;
`ifdef HK_SEQ_TIMESTAMP_EN
            r_ts       <= 32'h0;
`endif
        end else begin
            r_state    <= w_next;
            r_pps_sync <= {r_pps_sync[1:0], pps_i};
            // Any edge not accepted from IDLE (including the DONE cycle) is a miss.
            if (w_pps_edge && (r_state != S_IDLE))
                r_missed <= 1'b1;
`ifdef HK_SEQ_TIMESTAMP_EN
            if (w_pps_edge)
                r_ts <= r_ts + 32'd1;
`endif
            case (r_state)
                S_IDLE: begin
                    r_ch    <= 3'b0;
                    r_timer <= '0;
                end
                S_REQ: begin
                    // Ack takes priority over a timeout expiring on the same cycle.
                    if (wbm_ack_i) begin
                        r_data <= wbm_dat_i[15:0];
                        r_flag <= 1'b0;
                    end else if (w_timeout) begin
                        r_data <= 16'hDEAD;
                        r_flag <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STORE: begin
                    r_timer <= '0;
                    if (!w_last_ch)
                        r_ch <= r_ch + 3'd1;
                end
                S_HDR:   r_seq <= r_seq + 16'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_adr_o  = 16'h0;
        buf_we_o   = 1'b0;
        w_adr_full = 32'h0;
        buf_dat_o  = 32'h0;
        case (r_state)
            S_IDLE: if (w_pps_edge) w_next = S_REQ;
            S_REQ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_adr_o = 16'h0200 + {6'b0, xadc_reg(r_ch), 2'b00};
                if (wbm_ack_i || w_timeout)
                    w_next = S_STORE;
            end
            S_STORE: begin
                buf_we_o   = 1'b1;
                w_adr_full = {29'b0, r_ch} + 32'd1;
                buf_dat_o  = {r_flag, 7'b0, 5'b0, r_ch, r_data};
`ifdef HK_SEQ_TIMESTAMP_EN
                w_next = w_last_ch ? S_TSTAMP : S_REQ;
`else
                w_next = w_last_ch ? S_HDR : S_REQ;
`endif
            end
`ifdef HK_SEQ_TIMESTAMP_EN
            S_TSTAMP: begin
                buf_we_o   = 1'b1;
                w_adr_full = 32'(NUM_CH + 1);
                buf_dat_o  = r_ts;
                w_next     = S_HDR;
            end
`endif
            // Header goes last so a new seq implies all data words are already valid.
            S_HDR: begin
                buf_we_o   = 1'b1;
                w_adr_full = 32'h0;
                buf_dat_o  = {r_seq, 8'h00, 8'(NUM_CH)};
                w_next     = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign buf_adr_o = w_adr_full[BUF_AW-1:0];
    assign wbm_we_o  = 1'b0;
    assign wbm_dat_o = 32'h0;
    assign wbm_sel_o = 4'hF;
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = (r_state == S_DONE);
    assign missed_o  = r_missed;

endmodule

// File: tb/tb_surf4_hk_sequencer.sv
module tb_surf4_hk_sequencer;
    localparam int NUM_CH  = 6;
    localparam int TIMEOUT = 255;
    localparam int BUF_AW  = 5;
    localparam int NEVER   = 1000;

    logic clk_i = 1'b0;
    logic rst_i, pps_i;
    logic wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [15:0] wbm_adr_o;
    logic [31:0] wbm_dat_o, wbm_dat_i, buf_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        buf_we_o, busy_o, done_o, missed_o;
    logic [BUF_AW-1:0] buf_adr_o;

    surf4_hk_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT), .BUF_AW(BUF_AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pps_i(pps_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .buf_we_o(buf_we_o), .buf_adr_o(buf_adr_o), .buf_dat_o(buf_dat_o),
        .busy_o(busy_o), .done_o(done_o), .missed_o(missed_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int unsigned delay; logic [31:0] data; } plan_t;
    typedef struct { logic [BUF_AW-1:0] adr; logic [31:0] dat; } wr_t;

    plan_t       plan_q[$];
    logic [15:0] wbadr_q[$];
    wr_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int unsigned m_seq = 0;
    int unsigned m_ts = 0;
    int          tbl[8] = '{'h00, 'h01, 'h02, 'h03, 'h06, 'h1A, 'h04, 'h05};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: describes one scan record from the slave plan.
    // An access whose ack arrives after TIMEOUT wait cycles is abandoned.
    task automatic plan_scan(input int unsigned dly[NUM_CH], input bit use_d0,
                             input logic [31:0] d0, input int extra_edges);
        plan_t p;
        wr_t   w;
        m_ts = m_ts + 1 + extra_edges;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            p.delay = dly[ch];
            p.data  = (use_d0 && ch == 0) ? d0 : $urandom;
            plan_q.push_back(p);
            wbadr_q.push_back(16'(32'h200 + tbl[ch] * 4));
            w.adr = BUF_AW'(ch + 1);
            if (dly[ch] > TIMEOUT)
                w.dat = 32'h8000_0000 + 32'(ch) * 32'h1_0000 + 32'hDEAD;
            else
                w.dat = 32'(ch) * 32'h1_0000 + {16'h0, p.data[15:0]};
            exp_q.push_back(w);
        end
`ifdef HK_SEQ_TIMESTAMP_EN
        w.adr = BUF_AW'(NUM_CH + 1);
        w.dat = m_ts;
        exp_q.push_back(w);
`endif
        w.adr = '0;
        w.dat = m_seq * 32'h1_0000 + NUM_CH;
        exp_q.push_back(w);
        m_seq = (m_seq + 1) % 65536;
    endtask

    task automatic pulse_pps(input bit check_lat);
        @(posedge clk_i); #1 pps_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        if (check_lat) check("cyc_before_latency", {31'b0, wbm_cyc_o}, 32'd0);
        @(posedge clk_i); #1;
        if (check_lat) check("cyc_at_3clk", {31'b0, wbm_cyc_o}, 32'd1);
        repeat (2) @(posedge clk_i);
        #1 pps_i = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 5000) begin
            @(posedge clk_i);
            n++;
        end
        #2 check("done_reached", done_cnt, target);
    endtask

    // WISHBONE slave: one plan entry per access, ack after plan.delay cycles of strobe.
    plan_t cur;
    int    s_cnt = 0;
    bit    s_active = 1'b0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            wbm_ack_i = 1'b0;
            s_active  = 1'b0;
        end else if (wbm_stb_o && !wbm_ack_i) begin
            if (!s_active) begin
                s_active = 1'b1;
                s_cnt    = 0;
                if (plan_q.size() == 0 || wbadr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wb_access: adr 0x%04h, no access expected", wbm_adr_o);
                    cur.delay = NEVER;
                    cur.data  = 32'h0;
                end else begin
                    cur = plan_q.pop_front();
                    check("wb_adr", {16'h0, wbm_adr_o}, {16'h0, wbadr_q.pop_front()});
                end
                check("wb_we_sel_dat", {wbm_we_o, wbm_sel_o, wbm_dat_o[26:0]}, {1'b0, 4'hF, 27'h0});
            end
            if (s_cnt == int'(cur.delay)) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = cur.data;
            end else begin
                s_cnt++;
            end
        end else begin
            wbm_ack_i = 1'b0;
            s_active  = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every buffer write and checks record ordering at done.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (buf_we_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_buf_we: adr %0d dat 0x%08h, none expected", buf_adr_o, buf_dat_o);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("buf_adr", {{(32-BUF_AW){1'b0}}, buf_adr_o}, {{(32-BUF_AW){1'b0}}, e.adr});
                    check("buf_dat", buf_dat_o, e.dat);
                end
            end
            if (done_o) begin
                done_cnt++;
                check("record_complete_at_done", exp_q.size(), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned dly[NUM_CH];
        int n;
        rst_i = 1'b1; pps_i = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        repeat (3) @(posedge clk_i);
        #1 check("reset_outputs",
                 {20'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o, buf_we_o, busy_o, done_o, missed_o, 5'h0},
                 32'h0);
        check("reset_buses", wbm_adr_o ^ buf_dat_o ^ {27'h0, buf_adr_o}, 32'h0);
        @(posedge clk_i); #2 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);

        // Single scan, fixed ack delay, known data on reg 0x00.
        foreach (dly[i]) dly[i] = 1;
        plan_scan(dly, 1'b1, 32'h0000_9A50, 0);
        pulse_pps(1'b1);
        wait_done(1);

        // Second scan: header seq 1.
        foreach (dly[i]) dly[i] = $urandom_range(0, 4);
        plan_scan(dly, 1'b0, 32'h0, 0);
        pulse_pps(1'b1);
        wait_done(2);

        // No ack on ch2; ack exactly on the timeout cycle on ch1 (ack wins); one cycle late on ch4.
        foreach (dly[i]) dly[i] = $urandom_range(0, 3);
        dly[2] = NEVER;
        dly[1] = TIMEOUT;
        dly[4] = TIMEOUT + 1;
        plan_scan(dly, 1'b0, 32'h0, 0);
        pulse_pps(1'b1);
        wait_done(3);
        repeat (5) @(posedge clk_i);
        #1 check("missed_clear_before_overlap", {31'b0, missed_o}, 32'd0);

        // Randomized scans with random ack delays and occasional dead slaves.
        for (int s = 0; s < 6; s++) begin
            foreach (dly[i]) dly[i] = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 6);
            plan_scan(dly, 1'b0, 32'h0, 0);
            pulse_pps(1'b1);
            wait_done(4 + s);
            repeat ($urandom_range(1, 20)) @(posedge clk_i);
        end

        // Second PPS mid-scan: one record only, sticky miss flag.
        foreach (dly[i]) dly[i] = 5;
        plan_scan(dly, 1'b0, 32'h0, 1);
        pulse_pps(1'b1);
        repeat (4) @(posedge clk_i);
        pulse_pps(1'b0);
        wait_done(10);
        repeat (60) @(posedge clk_i);
        #1 check("missed_set", {31'b0, missed_o}, 32'd1);
        check("single_record_after_miss", done_cnt, 10);

        // Reset while ch3 is being requested.
        foreach (dly[i]) dly[i] = 1;
        dly[3] = NEVER;
        plan_scan(dly, 1'b0, 32'h0, 0);
        pulse_pps(1'b1);
        n = 0;
        while (!(wbm_cyc_o && wbm_adr_o == 16'h020C) && n < 500) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("reached_ch3_req", {31'b0, wbm_cyc_o}, 32'd1);
        @(posedge clk_i); #2 rst_i = 1'b1;
        #1 check("abort_cyc_stb_busy", {29'b0, wbm_cyc_o, wbm_stb_o, busy_o}, 32'd0);
        exp_q.delete(); plan_q.delete(); wbadr_q.delete();
        m_seq = 0; m_ts = 0;
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1 check("missed_cleared_by_reset", {31'b0, missed_o}, 32'd0);
        repeat (40) @(posedge clk_i);
        foreach (dly[i]) dly[i] = $urandom_range(0, 3);
        plan_scan(dly, 1'b0, 32'h0, 0);
        pulse_pps(1'b1);
        wait_done(11);
        repeat (10) @(posedge clk_i);
        #1 check("scoreboard_drained", exp_q.size() + plan_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
